vector_memory_sequencer: RTL and testbench

Memory-stage access controller that consumes the ExecuteMemory pipeline register outputs and drives the byte-wide synchronous data memory. Scalar loads and stores complete in one access cycle. 128-bit vector stores and loads are serialized into 16 byte beats while the pipeline is stalled. It is the receiving end of the execute-to-memory interface and feeds the MemoryWriteback register.

---
 rtl/vector_memory_sequencer_if.sv | 22 ++
 rtl/vector_memory_sequencer.sv | 122 ++++++++++++
 tb/tb_vector_memory_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vector_memory_sequencer_if.sv
// Execute-to-memory request bundle: the ExecuteMemory register drives it,
// the memory-stage sequencer consumes it.
interface vector_memory_sequencer_if;
    logic         write_memory_enable_a_memory;
    logic         write_memory_enable_b_memory;
    logic         load_scalar_memory;
    logic         load_vector_memory;
    logic [7:0]   alu_result_memory;
    logic [15:0]  srcB_memory;
    logic [127:0] vector_srcB_memory;

    modport master (
        output write_memory_enable_a_memory, write_memory_enable_b_memory,
               load_scalar_memory, load_vector_memory,
               alu_result_memory, srcB_memory, vector_srcB_memory
    );
    modport slave (
        input  write_memory_enable_a_memory, write_memory_enable_b_memory,
               load_scalar_memory, load_vector_memory,
               alu_result_memory, srcB_memory, vector_srcB_memory
    );
endinterface

// File: rtl/vector_memory_sequencer.sv
// Memory-stage controller: single-cycle scalar accesses, and 128-bit vector
// loads/stores serialized into 16 byte beats while the pipeline is stalled.
module vector_memory_sequencer #(
    parameter int ADDR_WIDTH   = 8,
    parameter int VECTOR_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    vector_memory_sequencer_if.slave      ex_mem,
    input  logic [7:0]                    mem_read_data,
    output logic [ADDR_WIDTH-1:0]         mem_address,
    output logic                          mem_write_enable,
    output logic [7:0]                    mem_write_data,
    output logic                          stall_memory,
    output logic [15:0]                   scalar_load_data,
    output logic [VECTOR_BYTES*8-1:0]     vector_load_data,
    output logic                          vector_load_done
);
    typedef enum logic [1:0] {IDLE, VSTORE, VLOAD, VDRAIN} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic [VECTOR_BYTES*8-1:0] sdata_q, sdata_d;
    logic [VECTOR_BYTES*8-1:0] vld_q, vld_d;
    logic                      done_q, done_d;
    logic [ADDR_WIDTH-1:0]     beat_addr;
    logic [3:0]                prev_idx;

    // Upper half of the scalar store operand never reaches the byte-wide memory.
    logic unused_srcb_hi;
    assign unused_srcb_hi = ^ex_mem.srcB_memory[15:8];

    assign beat_addr        = base_q + {{(ADDR_WIDTH-4){1'b0}}, cnt_q};
    assign prev_idx         = cnt_q - 4'd1;
    assign scalar_load_data = {8'h00, mem_read_data};
    assign vector_load_data = vld_q;
    assign vector_load_done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            sdata_q <= '0;
            vld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            sdata_q <= sdata_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        base_d           = base_q;
        sdata_d          = sdata_q;
        vld_d            = vld_q;
        done_d           = 1'b0;
        mem_address      = ex_mem.alu_result_memory;
        mem_write_enable = 1'b0;
        mem_write_data   = 8'h00;
        stall_memory     = 1'b0;

        case (state_q)
            IDLE: begin
                // Beat 0 of a vector op goes out in the accept cycle itself.
                if (ex_mem.write_memory_enable_b_memory) begin
                    base_d           = ex_mem.alu_result_memory;
                    sdata_d          = ex_mem.vector_srcB_memory;
                    cnt_d            = 4'd1;
                    mem_write_enable = 1'b1;
                    mem_write_data   = ex_mem.vector_srcB_memory[7:0];
                    stall_memory     = 1'b1;
                    state_d          = VSTORE;
                end else if (ex_mem.load_vector_memory) begin
                    base_d       = ex_mem.alu_result_memory;
                    vld_d        = '0;
                    cnt_d        = 4'd1;
                    stall_memory = 1'b1;
                    state_d      = VLOAD;
                end else if (ex_mem.write_memory_enable_a_memory) begin
                    mem_write_enable = 1'b1;
                    mem_write_data   = ex_mem.srcB_memory[7:0];
                end
            end
            VSTORE: begin
                mem_address      = beat_addr;
                mem_write_enable = 1'b1;
                mem_write_data   = sdata_q[{cnt_q, 3'b000} +: 8];
                stall_memory     = (cnt_q != 4'd15);
                cnt_d            = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = IDLE;
            end
            VLOAD: begin
                // Read data lags the address by one cycle, so capture the previous beat.
                mem_address                      = beat_addr;
                stall_memory                     = 1'b1;
                vld_d[{prev_idx, 3'b000} +: 8]   = mem_read_data;
                cnt_d                            = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = VDRAIN;
            end
            VDRAIN: begin
                vld_d[127:120] = mem_read_data;
                done_d         = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            mem_write_enable = 1'b0;
            mem_write_data   = 8'h00;
            stall_memory     = 1'b0;
        end
    end
endmodule

// File: tb/tb_vector_memory_sequencer.sv
// Scoreboard bench: expected memory writes and vector load results are queued
// as stimulus is driven and retired as the DUT produces them.
module tb_vector_memory_sequencer;
    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   mem_read_data;
    logic [7:0]   mem_address;
    logic         mem_write_enable;
    logic [7:0]   mem_write_data;
    logic         stall_memory;
    logic [15:0]  scalar_load_data;
    logic [127:0] vector_load_data;
    logic         vector_load_done;

    vector_memory_sequencer_if ex_if();

    vector_memory_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .ex_mem           (ex_if.slave),
        .mem_read_data    (mem_read_data),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .stall_memory     (stall_memory),
        .scalar_load_data (scalar_load_data),
        .vector_load_data (vector_load_data),
        .vector_load_done (vector_load_done)
    );

    always #5 clk = ~clk;

    logic [7:0]   mem [256];
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address] <= mem_write_data;
        mem_read_data <= mem[mem_address];
    end

    int total = 0;
    int bad   = 0;
    logic [15:0]  wq[$];
    logic [127:0] lq[$];
    logic [15:0]  wexp;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write_enable) begin
            if (reset) chk("wr_in_reset", 1, 0);
            else if (wq.size() == 0) chk("wr_extra", {mem_address, mem_write_data}, 0);
            else begin
                wexp = wq.pop_front();
                chk("wr_addr", mem_address, wexp[15:8]);
                chk("wr_data", mem_write_data, wexp[7:0]);
            end
        end
        if (vector_load_done) begin
            if (lq.size() == 0) chk("ld_extra", 1, 0);
            else chk("vld_data", vector_load_data, lq.pop_front());
        end
    end

    task automatic idle_inputs();
        ex_if.write_memory_enable_a_memory = 1'b0;
        ex_if.write_memory_enable_b_memory = 1'b0;
        ex_if.load_scalar_memory           = 1'b0;
        ex_if.load_vector_memory           = 1'b0;
    endtask

    // Vector store of bytes first+i at base; also presents a scalar load when asked.
    task automatic vstore(input logic [7:0] base, input logic [7:0] first, input bit with_ld,
                          input string tag);
        logic [127:0] v;
        int st;
        for (int i = 0; i < 16; i++) begin
            v[i*8 +: 8] = first + 8'(i);
            wq.push_back({base + 8'(i), first + 8'(i)});
        end
        ex_if.alu_result_memory            = base;
        ex_if.vector_srcB_memory           = v;
        ex_if.write_memory_enable_b_memory = 1'b1;
        ex_if.load_scalar_memory           = with_ld;
        st = 0;
        @(negedge clk);
        chk({tag, "_accept_we"}, mem_write_enable, 1);
        if (stall_memory) st++;
        @(posedge clk); #1 idle_inputs();
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            if (stall_memory) st++;
        end
        chk({tag, "_stall_cycles"}, st, 15);
        chk({tag, "_writes_left"}, wq.size(), 0);
    endtask

    task automatic scalar_load(input logic [7:0] a, input logic [7:0] exp, input string tag);
        ex_if.alu_result_memory  = a;
        ex_if.load_scalar_memory = 1'b1;
        @(negedge clk);
        chk({tag, "_stall"}, stall_memory, 0);
        @(posedge clk); #1 idle_inputs();
        @(negedge clk);
        chk({tag, "_data"}, scalar_load_data, {8'h00, exp});
    endtask

    initial begin
        logic [127:0] ev;
        int st, done_at;
        idle_inputs();
        ex_if.alu_result_memory  = 8'h00;
        ex_if.srcB_memory        = 16'h0000;
        ex_if.vector_srcB_memory = '0;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", vector_load_done, 0);
        chk("rst_vdata", vector_load_data, 0);
        chk("rst_stall", stall_memory, 0);
        chk("rst_we", mem_write_enable, 0);
        chk("rst_wdata", mem_write_data, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Scalar store
        ex_if.alu_result_memory            = 8'h10;
        ex_if.srcB_memory                  = 16'h00A5;
        ex_if.write_memory_enable_a_memory = 1'b1;
        wq.push_back(16'h10A5);
        @(negedge clk);
        chk("sst_stall", stall_memory, 0);
        @(posedge clk); #1 idle_inputs();
        repeat (2) @(negedge clk);
        chk("sst_writes_left", wq.size(), 0);

        // Scalar load
        mem[8'h33] = 8'h7E;
        @(posedge clk); #1;
        scalar_load(8'h33, 8'h7E, "sld");

        // Vector stores, plain and with a competing scalar load
        @(posedge clk); #1;
        vstore(8'h20, 8'h01, 1'b0, "vst");
        @(posedge clk); #1;
        vstore(8'h40, 8'h90, 1'b1, "vst_prio");

        // Vector load with address wrap
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) ev[i*8 +: 8] = 8'hF8 + 8'(i);
        lq.push_back(ev);
        ex_if.alu_result_memory  = 8'hF8;
        ex_if.load_vector_memory = 1'b1;
        st = 0; done_at = -1;
        @(negedge clk);
        if (stall_memory) st++;
        @(posedge clk); #1 idle_inputs();
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (stall_memory) st++;
            if (vector_load_done && done_at < 0) done_at = c;
        end
        chk("vld_done_latency", done_at, 17);
        chk("vld_stall_cycles", st, 16);
        chk("vld_results_left", lq.size(), 0);

        // Reset in the middle of a vector store at base 0
        mem[8'h05] = 8'h55;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) wq.push_back({8'(i), 8'hC0 + 8'(i)});
        for (int i = 0; i < 16; i++) ev[i*8 +: 8] = 8'hC0 + 8'(i);
        ex_if.alu_result_memory            = 8'h00;
        ex_if.vector_srcB_memory           = ev;
        ex_if.write_memory_enable_b_memory = 1'b1;
        @(posedge clk); #1 idle_inputs();
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_stall", stall_memory, 0);
        chk("mid_rst_we", mem_write_enable, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", stall_memory, 0);
        chk("post_rst_we", mem_write_enable, 0);
        chk("post_rst_vdata", vector_load_data, 0);
        chk("post_rst_writes_left", wq.size(), 0);
        @(posedge clk); #1;
        scalar_load(8'h03, 8'hC3, "rst_sld_written");
        @(posedge clk); #1;
        scalar_load(8'h05, 8'h55, "rst_sld_untouched");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
